// File: rtl/flex_pts_tx.sv
// ---------------------------------------------------------------------------
// flex_pts_tx
// Framed parallel-to-serial transmitter for the serial link.
//
// A word is captured on a valid/ready handshake. The line then carries a
// start bit (0), NUM_BITS data bits, an optional even-parity bit and a stop
// bit (1). Each bit is held on the line for BIT_PERIOD clocks.
//
// Parameters
//   NUM_BITS    data bits per frame (>= 2)
//   SHIFT_MSB   1: MSB first, 0: LSB first
//   BIT_PERIOD  clocks per line bit (>= 1)
//   PARITY_EN   1: append even parity (XOR of the data bits) after the data
//
// Ports
//   clk         system clock, rising edge
//   n_rst       synchronous active-low reset
//   tx_data     word to send, sampled only on an accepting edge
//   tx_valid    tx_data is valid
//   tx_ready    high only while idle
//   serial_out  registered line output, idle high
//   tx_busy     a frame is in progress
//   tx_done     one-clock pulse on the last clock of the stop bit
// ---------------------------------------------------------------------------
module flex_pts_tx #(
  parameter int NUM_BITS   = 8,
  parameter int SHIFT_MSB  = 0,
  parameter int BIT_PERIOD = 10,
  parameter int PARITY_EN  = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                serial_out,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int CW = $clog2(BIT_PERIOD + 1);
  localparam int BW = $clog2(NUM_BITS);
  localparam logic [CW-1:0] PER_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       per_cnt_reg, per_cnt_next;
  logic [BW-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [NUM_BITS-1:0] shift_reg, shift_next;
  logic [NUM_BITS-1:0] shift_adv;
  logic                parity_reg, parity_next;
  logic                serial_reg, serial_next;
  logic                accept;
  logic                per_last;
  logic                bit_last;

  assign accept   = tx_valid && (state_reg == IDLE);
  assign per_last = (per_cnt_reg == PER_LAST);
  assign bit_last = (bit_cnt_reg == BIT_LAST);

  // Shift register advanced by one bit: the next bit to send always sits at
  // the outgoing end (bit 0 for LSB-first, bit NUM_BITS-1 for MSB-first).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BITS; gi++) begin : g_adv
      if (SHIFT_MSB != 0) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shift_adv[gi] = 1'b0;
        end else begin : g_move
          assign shift_adv[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == NUM_BITS - 1) begin : g_fill
          assign shift_adv[gi] = 1'b0;
        end else begin : g_move
          assign shift_adv[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      per_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      serial_reg  <= 1'b1;
    end else begin
      state_reg   <= state_next;
      per_cnt_reg <= per_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      serial_reg  <= serial_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    per_cnt_next = per_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    serial_next  = 1'b1;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = START;
          per_cnt_next = '0;
          bit_cnt_next = '0;
          shift_next   = tx_data;
          // Parity is taken from the word as captured, since the shift
          // register is consumed while the data bits go out.
          parity_next  = ^tx_data;
        end
      end
      START: begin
        if (per_last) begin
          state_next   = DATA;
          per_cnt_next = '0;
        end else begin
          per_cnt_next = per_cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (per_last) begin
          per_cnt_next = '0;
          if (bit_last) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
            shift_next   = shift_adv;
          end
        end else begin
          per_cnt_next = per_cnt_reg + CW'(1);
        end
      end
      PARITY: begin
        if (per_last) begin
          state_next   = STOP;
          per_cnt_next = '0;
        end else begin
          per_cnt_next = per_cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (per_last) begin
          state_next   = IDLE;
          per_cnt_next = '0;
        end else begin
          per_cnt_next = per_cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        per_cnt_next = '0;
      end
    endcase

    // The line is registered, so it is derived from the upcoming state:
    // this keeps serial_out aligned with state_reg on every clock.
    unique case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = (SHIFT_MSB != 0) ? shift_next[NUM_BITS-1] : shift_next[0];
      PARITY:  serial_next = parity_next;
      default: serial_next = 1'b1;
    endcase
  end

  assign serial_out = serial_reg;
  assign tx_ready   = (state_reg == IDLE);
  assign tx_busy    = (state_reg != IDLE);
  assign tx_done    = (state_reg == STOP) && per_last;

endmodule

// File: tb/tb_flex_pts_tx.sv
// ---------------------------------------------------------------------------
// tb_flex_pts_tx
// Three transmitter configurations share one clock, reset and data bus:
//   dut 0: NUM_BITS=8, BIT_PERIOD=4, LSB first, no parity
//   dut 1: NUM_BITS=8, BIT_PERIOD=4, MSB first, even parity
//   dut 2: NUM_BITS=4, BIT_PERIOD=1, LSB first, no parity
// Each frame's expected line waveform is built from the framing rules and
// compared clock by clock against the selected transmitter.
// ---------------------------------------------------------------------------
module tb_flex_pts_tx;

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data;
  logic [2:0] valid_v;
  wire  [2:0] ready_v;
  wire  [2:0] so_v;
  wire  [2:0] busy_v;
  wire  [2:0] done_v;

  int checks = 0;
  int errors = 0;

  int cfg_n   [3] = '{8, 8, 4};
  int cfg_bp  [3] = '{4, 4, 1};
  int cfg_msb [3] = '{0, 1, 0};
  int cfg_par [3] = '{0, 1, 0};

  bit exp_line[$];

  flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .BIT_PERIOD(4), .PARITY_EN(0)) dut_a (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_valid   (valid_v[0]),
    .tx_ready   (ready_v[0]),
    .serial_out (so_v[0]),
    .tx_busy    (busy_v[0]),
    .tx_done    (done_v[0])
  );

  flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .BIT_PERIOD(4), .PARITY_EN(1)) dut_b (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_valid   (valid_v[1]),
    .tx_ready   (ready_v[1]),
    .serial_out (so_v[1]),
    .tx_busy    (busy_v[1]),
    .tx_done    (done_v[1])
  );

  flex_pts_tx #(.NUM_BITS(4), .SHIFT_MSB(0), .BIT_PERIOD(1), .PARITY_EN(0)) dut_c (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data[3:0]),
    .tx_valid   (valid_v[2]),
    .tx_ready   (ready_v[2]),
    .serial_out (so_v[2]),
    .tx_busy    (busy_v[2]),
    .tx_done    (done_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge. Presents the word, lets it be accepted on the
  // next rising edge and checks every clock of the frame plus the idle clock
  // that follows. With hold=1 tx_valid stays high and tx_data keeps changing
  // during the frame; the caller must then chain another frame or clear
  // tx_valid at the returning falling edge.
  task automatic run_frame(input int d, input logic [7:0] w, input bit hold);
    int         n;
    int         bp;
    logic [7:0] wm;
    n  = cfg_n[d];
    bp = cfg_bp[d];
    wm = w & 8'((1 << n) - 1);
    exp_line.delete();
    exp_line.push_back(1'b0);
    for (int i = 0; i < n; i++)
      exp_line.push_back((cfg_msb[d] != 0) ? wm[n-1-i] : wm[i]);
    if (cfg_par[d] != 0) exp_line.push_back(^wm);
    exp_line.push_back(1'b1);
    $display("frame dut=%0d word=%02h hold=%0d bits=%0d clocks=%0d",
             d, wm, hold, exp_line.size(), exp_line.size() * bp);

    tx_data    = w;
    valid_v[d] = 1'b1;
    chk("ready_pre", ready_v[d], 1);
    @(posedge clk);
    for (int b = 0; b < exp_line.size(); b++) begin
      for (int p = 0; p < bp; p++) begin
        @(negedge clk);
        if (hold) tx_data = 8'($urandom);
        else      valid_v[d] = 1'b0;
        chk("line", so_v[d], exp_line[b]);
        chk("busy", busy_v[d], 1);
        chk("ready", ready_v[d], 0);
        chk("done", done_v[d], ((b == exp_line.size() - 1) && (p == bp - 1)) ? 1 : 0);
      end
    end
    @(negedge clk);
    chk("idle_ready", ready_v[d], 1);
    chk("idle_busy", busy_v[d], 0);
    chk("idle_line", so_v[d], 1);
    chk("idle_done", done_v[d], 0);
  endtask

  initial begin
    int         d;
    logic [7:0] w;
    bit         hold;

    n_rst   = 1'b0;
    valid_v = '0;
    tx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_line", so_v[i], 1);
      chk("rst_ready", ready_v[i], 1);
      chk("rst_busy", busy_v[i], 0);
      chk("rst_done", done_v[i], 0);
    end
    n_rst = 1'b1;
    @(negedge clk);

    // Directed frames from the framing examples.
    run_frame(0, 8'hA5, 1'b0);
    run_frame(1, 8'hA5, 1'b0);
    run_frame(1, 8'h07, 1'b0);
    run_frame(2, 8'h06, 1'b0);

    // tx_valid held with changing data: frame unaffected, back-to-back
    // frame starts after exactly one idle clock.
    run_frame(0, 8'h3C, 1'b1);
    run_frame(0, 8'hC3, 1'b0);

    // Reset during data bit 3 of dut 0 (0x3C LSB first: bit 3 = 1).
    tx_data    = 8'h3C;
    valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_bit3", so_v[0], 1);
    chk("abort_busy_pre", busy_v[0], 1);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    chk("abort_line", so_v[0], 1);
    chk("abort_ready", ready_v[0], 1);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_done", done_v[0], 0);
    $display("reset abort dut=0 during data bit 3");
    repeat (12) begin
      @(negedge clk);
      chk("abort_quiet_done", done_v[0], 0);
      chk("abort_quiet_line", so_v[0], 1);
    end
    run_frame(0, 8'h5A, 1'b0);

    // Randomized frames across all three configurations.
    for (int k = 0; k < 24; k++) begin
      d    = int'($urandom_range(0, 2));
      w    = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      run_frame(d, w, hold);
      if (hold) run_frame(d, 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
